mcu_sequencer: RTL and testbench

Fetch/decode/execute sequencer for the 12-bit microcontroller; the issuing side of the ALU interface. It fetches 12-bit instructions from program memory, reads operands from data memory, drives the ALU's enable, mode, operands and current flags, and commits the ALU result and flags to the accumulator, flags register or data memory. It sits between the program/data memories and the combinational ALU.

---
 rtl/mcu_pkg.sv | 61 ++++++
 rtl/mcu_sequencer_instr_decode.sv | 45 ++++
 rtl/mcu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mcu_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the 12-bit microcontroller sequencer.
// Holds the instruction class and control sub-codes, the instruction
// bit-field positions, the flag indices, the FSM state encoding and the
// ALU mode constants.
package mcu_pkg;

    // Instruction class, taken from instr[11:10]
    typedef enum logic [1:0] {
        CLS_CTRL  = 2'b00,
        CLS_MTYPE = 2'b01,
        CLS_LDI   = 2'b10,
        CLS_HALT  = 2'b11
    } instr_class_t;

    // Control sub-codes, taken from instr[9:8]
    localparam logic [1:0] CTRL_NOP = 2'b00;
    localparam logic [1:0] CTRL_JMP = 2'b01;
    localparam logic [1:0] CTRL_JZ  = 2'b10;
    localparam logic [1:0] CTRL_JC  = 2'b11;

    // Instruction bit-field positions
    localparam int CLASS_HI = 11;
    localparam int CLASS_LO = 10;
    localparam int SUB_HI   = 9;
    localparam int SUB_LO   = 8;
    localparam int MODE_HI  = 9;
    localparam int MODE_LO  = 6;
    localparam int DEST_BIT = 5;
    localparam int ADDR_HI  = 3;
    localparam int ADDR_LO  = 0;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    // Flag indices within {Z,C,S,O}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // ALU mode codes; the sequencer passes these through untouched
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;

    // Extract the instruction class from an instruction word
    function automatic instr_class_t get_class(input logic [11:0] instr);
        return instr_class_t'(instr[CLASS_HI:CLASS_LO]);
    endfunction

endpackage

// File: rtl/mcu_sequencer_instr_decode.sv
// instr_decode: combinational instruction decoder for mcu_sequencer.
// Ports:
//   ir         in   12  registered instruction word
//   flag_z     in   1   current Z flag
//   flag_c     in   1   current C flag
//   iclass     out  2   instruction class (instr_class_t encoding)
//   jump_taken out  1   control instruction loads PC with its target
//   mode       out  4   ALU mode field
//   dest       out  1   M-type destination (0 = ACC, 1 = DMEM)
//   addr       out  4   M-type data memory address
//   imm        out  8   immediate / jump target field
module instr_decode
    import mcu_pkg::*;
(
    input  logic [11:0] ir,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic [1:0]  iclass,
    output logic        jump_taken,
    output logic [3:0]  mode,
    output logic        dest,
    output logic [3:0]  addr,
    output logic [7:0]  imm
);

    assign iclass = get_class(ir);
    assign mode   = ir[MODE_HI:MODE_LO];
    assign dest   = ir[DEST_BIT];
    assign addr   = ir[ADDR_HI:ADDR_LO];
    assign imm    = ir[IMM_HI:IMM_LO];

    // Only control instructions can redirect the PC; NOP never does
    always_comb begin
        jump_taken = 1'b0;
        if (iclass == CLS_CTRL) begin
            case (ir[SUB_HI:SUB_LO])
                CTRL_JMP: jump_taken = 1'b1;
                CTRL_JZ:  jump_taken = flag_z;
                CTRL_JC:  jump_taken = flag_c;
                default:  jump_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: fetch/decode/execute sequencer for the 12-bit
// microcontroller, issuing side of the combinational ALU.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   hold               freezes every register and the FSM while high
//   pmem_addr/rdata    program memory, synchronous read, 1-cycle latency
//   dmem_addr/rdata    data memory read port, 1-cycle latency
//   dmem_wdata/we      data memory write port, single-cycle strobe
//   alu_en/mode        ALU enable and mode (instr[9:6])
//   alu_op1/op2        accumulator and data memory operand
//   alu_cflags         current flags {Z,C,S,O}
//   alu_result/flags   ALU result and resulting flags
//   acc                accumulator, for observation
//   halted             high once HALT has executed
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 8,
    parameter int              DADDR_W  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    output logic [PC_W-1:0]    pmem_addr,
    input  logic [11:0]        pmem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    output logic               alu_en,
    output logic [3:0]         alu_mode,
    output logic [DATA_W-1:0]  alu_op1,
    output logic [DATA_W-1:0]  alu_op2,
    output logic [3:0]         alu_cflags,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [3:0]         alu_flags,
    output logic [DATA_W-1:0]  acc,
    output logic               halted
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [11:0]       ir;
    logic [3:0]        flags;

    logic [1:0]        dec_class;
    logic              dec_jump;
    logic [3:0]        dec_mode;
    logic              dec_dest;
    logic [3:0]        dec_addr;
    logic [7:0]        dec_imm;

    instr_decode u_decode (
        .ir         (ir),
        .flag_z     (flags[FLAG_Z]),
        .flag_c     (flags[FLAG_C]),
        .iclass     (dec_class),
        .jump_taken (dec_jump),
        .mode       (dec_mode),
        .dest       (dec_dest),
        .addr       (dec_addr),
        .imm        (dec_imm)
    );

    // Next state: hold keeps the current state so it re-executes in full
    always_comb begin
        state_next = state;
        if (!hold) begin
            case (state)
                ST_FETCH:  state_next = ST_LOAD;
                ST_LOAD:   state_next = ST_DECODE;
                ST_DECODE: begin
                    case (dec_class)
                        CLS_MTYPE: state_next = ST_EXEC;
                        CLS_HALT:  state_next = ST_HALT;
                        default:   state_next = ST_FETCH;
                    endcase
                end
                ST_EXEC:   state_next = ST_FETCH;
                ST_HALT:   state_next = ST_HALT;
                default:   state_next = ST_FETCH;
            endcase
        end
    end

    // Memory and ALU drives decode from the registered state and IR; the
    // strobes are masked by hold so a frozen EXEC commits nothing
    always_comb begin
        pmem_addr  = pc;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        alu_en     = 1'b0;
        alu_mode   = '0;
        alu_op2    = '0;
        case (state)
            ST_DECODE: begin
                if (dec_class == CLS_MTYPE) begin
                    dmem_addr = DADDR_W'(dec_addr);
                end
            end
            ST_EXEC: begin
                dmem_addr = DADDR_W'(dec_addr);
                alu_mode  = dec_mode;
                alu_op2   = dmem_rdata;
                alu_en    = !hold;
                if (dec_dest) begin
                    dmem_we    = !hold;
                    dmem_wdata = alu_result;
                end
            end
            default: ;
        endcase
    end

    assign alu_op1    = acc;
    assign alu_cflags = flags;
    assign halted     = (state == ST_HALT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Architectural registers; jump targets override the PC that LOAD
    // already incremented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
            flags <= '0;
        end else if (!hold) begin
            case (state)
                ST_LOAD: begin
                    ir <= pmem_rdata;
                    pc <= pc + PC_ONE;
                end
                ST_DECODE: begin
                    if (dec_class == CLS_CTRL && dec_jump) begin
                        pc <= PC_W'(dec_imm);
                    end else if (dec_class == CLS_LDI) begin
                        acc <= DATA_W'(dec_imm);
                    end
                end
                ST_EXEC: begin
                    flags <= alu_flags;
                    if (!dec_dest) begin
                        acc <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed self-checking bench for mcu_sequencer.
// Provides behavioural program/data memories with 1-cycle read latency
// and an independent ALU model; expected data memory writes are queued
// up front and popped by a write monitor as the DUT strobes dmem_we.
module tb_mcu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [7:0]  pmem_addr;
    logic [11:0] pmem_rdata;
    logic [3:0]  dmem_addr;
    logic [7:0]  dmem_rdata;
    logic [7:0]  dmem_wdata;
    logic        dmem_we;
    logic        alu_en;
    logic [3:0]  alu_mode;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [3:0]  alu_cflags;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags;
    logic [7:0]  acc;
    logic        halted;

    logic [11:0] pmem [256];
    logic [7:0]  dmem [16];

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t expWrites[$];
    wr_t popped;

    int errors     = 0;
    int checks     = 0;
    int writeCount = 0;

    mcu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .pmem_addr  (pmem_addr),
        .pmem_rdata (pmem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .alu_en     (alu_en),
        .alu_mode   (alu_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_cflags (alu_cflags),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .acc        (acc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories
    always @(posedge clk) begin
        pmem_rdata <= pmem[pmem_addr];
        dmem_rdata <= dmem[dmem_addr];
        if (dmem_we === 1'b1) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    // Reference ALU: ADD, SUB, AND, everything else passes op2
    logic [8:0] aluWide;
    always_comb begin
        aluWide    = 9'd0;
        alu_result = alu_op2;
        alu_flags  = 4'b0000;
        case (alu_mode)
            4'b0000: begin
                aluWide    = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_result = aluWide[7:0];
                alu_flags  = {alu_result == 8'h00, aluWide[8], alu_result[7],
                              (alu_op1[7] == alu_op2[7]) && (alu_result[7] != alu_op1[7])};
            end
            4'b0001: begin
                aluWide    = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_result = aluWide[7:0];
                alu_flags  = {alu_result == 8'h00, aluWide[8], alu_result[7],
                              (alu_op1[7] != alu_op2[7]) && (alu_result[7] != alu_op1[7])};
            end
            4'b0100: begin
                alu_result = alu_op1 & alu_op2;
                alu_flags  = {alu_result == 8'h00, 1'b0, alu_result[7], 1'b0};
            end
            default: begin
                alu_result = alu_op2;
                alu_flags  = {alu_result == 8'h00, 1'b0, alu_result[7], 1'b0};
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic holdVal, input logic rstVal);
        hold  = holdVal;
        rst_n = rstVal;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (dmem_we === 1'b1) begin
            writeCount++;
            checks++;
            assert (expWrites.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_write: observed addr=%0h data=%0h expected no write",
                       dmem_addr, dmem_wdata);
            end
            if (expWrites.size() != 0) begin
                popped = expWrites.pop_front();
                checkOutput("wr_addr", 16'(dmem_addr), 16'(popped.a));
                checkOutput("wr_data", 16'(dmem_wdata), 16'(popped.d));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0);
        pmem_rdata = '0;
        dmem_rdata = '0;
        for (int i = 0; i < 256; i++) pmem[i] = 12'h000;
        for (int i = 0; i < 16; i++)  dmem[i] = 8'h00;
        pmem[8'h00] = 12'h805;   // LDI 0x05
        pmem[8'h01] = 12'h403;   // ADD dest ACC, addr 3
        pmem[8'h02] = 12'h810;   // LDI 0x10
        pmem[8'h03] = 12'h462;   // SUB dest DMEM, addr 2
        pmem[8'h04] = 12'h240;   // JZ 0x40
        pmem[8'h40] = 12'h320;   // JC 0x20 (not taken)
        pmem[8'h41] = 12'h1FF;   // JMP 0xFF
        pmem[8'hFF] = 12'h150;   // JMP 0x50
        pmem[8'h50] = 12'h880;   // LDI 0x80
        pmem[8'h51] = 12'h425;   // ADD dest DMEM, addr 5
        pmem[8'h52] = 12'h360;   // JC 0x60 (taken)
        pmem[8'h60] = 12'h526;   // AND dest DMEM, addr 6 (reset mid-EXEC)
        dmem[3] = 8'h0A;
        dmem[2] = 8'h10;
        dmem[5] = 8'h80;
        dmem[6] = 8'hFF;
        expWrites.push_back('{a: 4'd2, d: 8'h00});
        expWrites.push_back('{a: 4'd5, d: 8'h00});

        tick(3);
        checkOutput("rst_pc",     16'(pmem_addr),  16'h00);
        checkOutput("rst_acc",    16'(acc),        16'h00);
        checkOutput("rst_flags",  16'(alu_cflags), 16'h0);
        checkOutput("rst_we",     16'(dmem_we),    16'h0);
        checkOutput("rst_alu_en", 16'(alu_en),     16'h0);
        checkOutput("rst_halted", 16'(halted),     16'h0);
        applyStimulus(1'b0, 1'b1);

        tick(3);
        checkOutput("ldi_acc",   16'(acc),        16'h05);
        checkOutput("ldi_pc",    16'(pmem_addr),  16'h01);
        checkOutput("ldi_flags", 16'(alu_cflags), 16'h0);

        tick(2);
        checkOutput("add_decode_en", 16'(alu_en), 16'h0);
        tick(1);
        checkOutput("add_exec_en", 16'(alu_en),   16'h1);
        checkOutput("add_op1",     16'(alu_op1),  16'h05);
        checkOutput("add_op2",     16'(alu_op2),  16'h0A);
        checkOutput("add_mode",    16'(alu_mode), 16'h0);
        tick(1);
        checkOutput("add_after_en", 16'(alu_en),     16'h0);
        checkOutput("add_acc",      16'(acc),        16'h0F);
        checkOutput("add_flags",    16'(alu_cflags), 16'h0);
        checkOutput("add_op2_idle", 16'(alu_op2),    16'h00);

        tick(6);
        checkOutput("sub_mode", 16'(alu_mode), 16'h1);
        tick(1);
        checkOutput("sub_flags", 16'(alu_cflags), 16'b1000);
        checkOutput("sub_acc",   16'(acc),        16'h10);

        tick(3);
        checkOutput("jz_taken_pc", 16'(pmem_addr), 16'h40);
        tick(3);
        checkOutput("jc_not_taken_pc", 16'(pmem_addr), 16'h41);
        tick(3);
        checkOutput("jmp_ff_pc", 16'(pmem_addr), 16'hFF);
        tick(2);
        checkOutput("pc_wrap", 16'(pmem_addr), 16'h00);
        tick(1);
        checkOutput("jmp_50_pc", 16'(pmem_addr), 16'h50);

        tick(3);
        checkOutput("ldi80_acc", 16'(acc), 16'h80);
        tick(2);
        checkOutput("decode_dmem_addr", 16'(dmem_addr), 16'h5);
        @(posedge clk);
        #2;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_we",     16'(dmem_we), 16'h0);
            checkOutput("hold_alu_en", 16'(alu_en),  16'h0);
        end
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("release_we", 16'(dmem_we), 16'h1);
        tick(1);
        checkOutput("hold_flags",     16'(alu_cflags), 16'b1101);
        checkOutput("hold_resume_pc", 16'(pmem_addr),  16'h52);
        checkOutput("hold_acc",       16'(acc),        16'h80);
        checkOutput("hold_one_write", 16'(writeCount), 16'd2);

        tick(3);
        checkOutput("jc_taken_pc", 16'(pmem_addr), 16'h60);
        tick(2);
        @(posedge clk);
        #1;
        checkOutput("exec_we_before_rst", 16'(dmem_we), 16'h1);
        #1;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("rst_exec_we",     16'(dmem_we),    16'h0);
        checkOutput("rst_exec_alu_en", 16'(alu_en),     16'h0);
        checkOutput("rst_exec_pc",     16'(pmem_addr),  16'h00);
        checkOutput("rst_exec_acc",    16'(acc),        16'h00);
        checkOutput("rst_exec_flags",  16'(alu_cflags), 16'h0);
        pmem[8'h00] = 12'hC00;   // HALT
        tick(3);
        checkOutput("no_partial_write", 16'(dmem[6]),    16'hFF);
        checkOutput("write_count",      16'(writeCount), 16'd2);
        applyStimulus(1'b0, 1'b1);

        tick(2);
        checkOutput("pre_halt", 16'(halted), 16'h0);
        tick(1);
        checkOutput("halted",   16'(halted),    16'h1);
        checkOutput("halt_pc",  16'(pmem_addr), 16'h01);
        tick(5);
        checkOutput("halt_stays", 16'(halted),    16'h1);
        checkOutput("halt_pc_frozen", 16'(pmem_addr), 16'h01);
        checkOutput("halt_alu_en", 16'(alu_en), 16'h0);
        checkOutput("writes_drained", 16'(expWrites.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
